// File: rtl/sitcp_tx_arbiter.sv
// Round-robin multiplexer of N per-channel byte FIFOs onto the SiTCP TX port.
// Define SITCP_TX_HEADER_EN to prefix every burst with {4'hA,ch} and len-1.
module sitcp_tx_arbiter #(
  parameter int N_CH      = 4,
  parameter int FIFO_AW   = 9,
  parameter int MAX_BURST = 256
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MAIN_OPEN_ACK,
  input  logic              TX_FULL,
  output logic              TX_WR,
  output logic [7:0]        TX_DATA,
  input  logic [N_CH-1:0]   CH_WR,
  input  logic [8*N_CH-1:0] CH_DATA,
  output logic [N_CH-1:0]   CH_FULL,
  output logic [N_CH-1:0]   CH_OVF,
  output logic              BUSY
);
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

`ifdef SITCP_TX_HEADER_EN
  typedef enum logic [2:0] {IDLE, ARB, HDR0, HDR1, DATA} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARB, DATA} state_t;
`endif

  logic [FIFO_AW:0]   fill    [N_CH];
  logic [7:0]         rd_byte [N_CH];
  logic [N_CH-1:0]    wr_q;
  logic [8*N_CH-1:0]  data_q;
  logic               open_q, full_q, flush;
  state_t             state, state_n;
  logic [CW-1:0]      rr_ptr, g, arb_g;
  logic               arb_hit;
  logic [8:0]         len, burst_len;
  logic               pop, issue;
  logic [7:0]         issue_byte;

  assign flush = open_q & ~MAIN_OPEN_ACK;
  assign BUSY  = (state != IDLE);

  // Writes are staged one cycle so the full test sees a settled count.
  for (genvar i = 0; i < N_CH; i++) begin : g_fifo
    logic [7:0]         ram [DEPTH];
    logic [FIFO_AW-1:0] wp, rp;
    logic [FIFO_AW:0]   cnt;
    logic               ovf, do_wr, do_rd;

    assign do_wr      = wr_q[i] & (cnt != FULL_CNT);
    assign do_rd      = pop & (int'(g) == i);
    assign fill[i]    = cnt;
    assign rd_byte[i] = ram[rp];
    assign CH_FULL[i] = (cnt == FULL_CNT);
    assign CH_OVF[i]  = ovf;

    always_ff @(posedge CLK) begin
      if (do_wr) ram[wp] <= data_q[8*i +: 8];
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (wr_q[i] && !do_wr) ovf <= 1'b1;
        if (do_wr) wp <= wp + PTR_ONE;
        if (flush) begin
          rp  <= wp;
          cnt <= do_wr ? CNT_ONE : '0;
        end else begin
          if (do_rd) rp <= rp + PTR_ONE;
          if (do_wr && !do_rd) cnt <= cnt + CNT_ONE;
          else if (do_rd && !do_wr) cnt <= cnt - CNT_ONE;
        end
      end
    end
  end

  // Lowest offset from rr_ptr wins, so scan offsets downwards.
  always_comb begin
    arb_hit = 1'b0;
    arb_g   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (fill[(int'(rr_ptr) + k) % N_CH] != '0) begin
        arb_hit = 1'b1;
        arb_g   = CW'((int'(rr_ptr) + k) % N_CH);
      end
    end
    if (int'(fill[arb_g]) > MAX_BURST) burst_len = 9'(MAX_BURST);
    else burst_len = 9'(fill[arb_g]);
  end

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    issue      = 1'b0;
    issue_byte = rd_byte[g];
    if (!MAIN_OPEN_ACK) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: state_n = ARB;
        ARB: begin
`ifdef SITCP_TX_HEADER_EN
          if (arb_hit) state_n = HDR0;
`else
          if (arb_hit) state_n = DATA;
`endif
        end
`ifdef SITCP_TX_HEADER_EN
        HDR0: if (!full_q) begin
          issue      = 1'b1;
          issue_byte = {4'hA, 4'(g)};
          state_n    = HDR1;
        end
        HDR1: if (!full_q) begin
          issue      = 1'b1;
          issue_byte = 8'(len - 9'd1);
          state_n    = DATA;
        end
`endif
        DATA: if (!full_q) begin
          pop   = 1'b1;
          issue = 1'b1;
          if (len == 9'd1) state_n = ARB;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      g       <= '0;
      len     <= '0;
      TX_WR   <= 1'b0;
      TX_DATA <= '0;
      open_q  <= 1'b0;
      full_q  <= 1'b0;
      wr_q    <= '0;
      data_q  <= '0;
    end else begin
      state  <= state_n;
      open_q <= MAIN_OPEN_ACK;
      full_q <= TX_FULL;
      wr_q   <= CH_WR;
      data_q <= CH_DATA;
      TX_WR  <= issue;
      if (issue) TX_DATA <= issue_byte;
      if (MAIN_OPEN_ACK && state == ARB && arb_hit) begin
        g   <= arb_g;
        len <= burst_len;
      end
      if (pop) begin
        len <= len - 9'd1;
        if (len == 9'd1)
          rr_ptr <= (int'(g) == N_CH - 1) ? '0 : g + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sitcp_tx_arbiter.sv
// Bench for sitcp_tx_arbiter: queue-based burst model, directed and random steps.
// Honours SITCP_TX_HEADER_EN the same way as the design.
module tb_sitcp_tx_arbiter;
  localparam int NCH   = 4;
  localparam int AW    = 5;
  localparam int MAXB  = 4;
  localparam int DEPTH = 1 << AW;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             MAIN_OPEN_ACK = 1'b0;
  logic             TX_FULL = 1'b0;
  logic             TX_WR;
  logic [7:0]       TX_DATA;
  logic [NCH-1:0]   CH_WR = '0;
  logic [8*NCH-1:0] CH_DATA = '0;
  logic [NCH-1:0]   CH_FULL;
  logic [NCH-1:0]   CH_OVF;
  logic             BUSY;

  sitcp_tx_arbiter #(.N_CH(NCH), .FIFO_AW(AW), .MAX_BURST(MAXB)) dut (
    .CLK(CLK), .RST(RST), .MAIN_OPEN_ACK(MAIN_OPEN_ACK),
    .TX_FULL(TX_FULL), .TX_WR(TX_WR), .TX_DATA(TX_DATA),
    .CH_WR(CH_WR), .CH_DATA(CH_DATA), .CH_FULL(CH_FULL),
    .CH_OVF(CH_OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] mq [NCH][$];
  logic [7:0] exp_q [$];
  logic [7:0] out_q [$];
  int cq [$];
  int m_rr = 0;
  logic [NCH-1:0] ovf_m = '0;
  logic [NCH-1:0] full_m;
  logic f1 = 1'b0, f2 = 1'b0;
  int n_r, n2, n_end, nd, bud;
  logic [8*NCH-1:0] d;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // A byte may only appear if TX_FULL was low two edges back.
  always @(negedge CLK) begin
    if (TX_WR) begin
      out_q.push_back(TX_DATA);
      cq.push_back(cyc);
      chk("stall_rule", {31'd0, f2}, 32'd0);
    end
    f2 = f1;
    f1 = TX_FULL;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [NCH-1:0] mask,
                     input logic [8*NCH-1:0] data);
    CH_WR   = mask;
    CH_DATA = data;
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(data[8*c +: 8]);
        else ovf_m[c] = 1'b1;
      end
    end
    step();
    CH_WR = '0;
  endtask

  // Turn queued channel data into the expected serial stream.
  task automatic build();
    int gch, n;
    bit found;
    for (int c = 0; c < NCH; c++) full_m[c] = (mq[c].size() == DEPTH);
    forever begin
      found = 1'b0;
      gch = 0;
      for (int k = 0; k < NCH; k++) begin
        if (!found && mq[(m_rr + k) % NCH].size() != 0) begin
          gch = (m_rr + k) % NCH;
          found = 1'b1;
        end
      end
      if (!found) break;
      n = (mq[gch].size() > MAXB) ? MAXB : mq[gch].size();
`ifdef SITCP_TX_HEADER_EN
      exp_q.push_back(8'hA0 | 8'(gch));
      exp_q.push_back(8'(n - 1));
`endif
      for (int j = 0; j < n; j++) exp_q.push_back(mq[gch].pop_front());
      m_rr = (gch + 1) % NCH;
    end
  endtask

  task automatic drain(input bit rnd_full);
    int budget;
    budget = 4000;
    while (out_q.size() < exp_q.size() && budget > 0) begin
      TX_FULL = rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
      budget--;
    end
    TX_FULL = 1'b0;
    repeat (8) step();
    chk("drain_timeout", {31'd0, budget > 0}, 32'd1);
    chk("out_count", out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk("out_byte", out_q[i], exp_q[i]);
    chk("ch_ovf", CH_OVF, ovf_m);
    chk("ch_full_after", CH_FULL, 0);
    out_q.delete();
    cq.delete();
    exp_q.delete();
  endtask

  task automatic close_link();
    MAIN_OPEN_ACK = 1'b0;
    repeat (2) step();
  endtask

  task automatic open_link();
    repeat (3) step();
    build();
    MAIN_OPEN_ACK = 1'b1;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_tx_wr", TX_WR, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_ch_full", CH_FULL, 0);
    chk("rst_ch_ovf", CH_OVF, 0);
    chk("rst_busy", BUSY, 0);
    RST = 1'b0;
    step();

    // 10 bytes per channel, bursts of MAXB in round-robin order
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < NCH; c++) d[8*c +: 8] = 8'(16 * (c + 1) + j);
      put('1, d);
    end
    open_link();
    drain(1'b0);

    // three bytes on ch0 leave back-to-back
    close_link();
    put(4'b0001, {24'd0, 8'h11});
    put(4'b0001, {24'd0, 8'h22});
    put(4'b0001, {24'd0, 8'h33});
    open_link();
    repeat (20) step();
    for (int i = 1; i < cq.size(); i++)
      chk("consecutive", cq[i] - cq[0], i);
    chk("busy_open", BUSY, 1);
    drain(1'b0);

    // write-to-TX_WR latency on an idle open link
    mq[0].push_back(8'h5A);
    build();
    CH_WR = 4'b0001;
    CH_DATA = {24'd0, 8'h5A};
    step();
    CH_WR = '0;
    chk("lat_k0", TX_WR, 0);
    step();
    chk("lat_k1", TX_WR, 0);
    step();
    chk("lat_k2", TX_WR, 0);
    step();
    chk("lat_k3", TX_WR, 1);
    chk("lat_data", TX_DATA, exp_q[0]);
    drain(1'b0);

    // TX_FULL held high mid-burst
    close_link();
    for (int j = 0; j < 12; j++) put(4'b0010, {16'd0, 8'(8'hC0 + j), 8'd0});
    open_link();
    bud = 100;
    while (out_q.size() < 3 && bud > 0) begin
      step();
      bud--;
    end
    TX_FULL = 1'b1;
    @(negedge CLK);
    n_r = out_q.size();
    repeat (2) step();
    @(negedge CLK);
    n2 = out_q.size();
    repeat (18) step();
    @(negedge CLK);
    n_end = out_q.size();
    chk("stall_rise", {31'd0, n2 <= n_r + 1}, 32'd1);
    chk("stall_hold", n_end, n2);
    drain(1'b0);

    // overfill ch1 by one byte
    close_link();
    for (int j = 0; j <= DEPTH; j++) put(4'b0010, {16'd0, 8'(j), 8'd0});
    repeat (3) step();
    chk("full_ch_full", CH_FULL, {28'd0, mq[3].size() == DEPTH,
        mq[2].size() == DEPTH, mq[1].size() == DEPTH, mq[0].size() == DEPTH});
    chk("full_ch_ovf", CH_OVF, ovf_m);
    open_link();
    drain(1'b0);

    // link drop mid-burst flushes everything
    close_link();
    for (int j = 0; j < 25; j++) put(4'b0101, {8'd0, 8'(8'h80 + j), 8'd0, 8'(j)});
    open_link();
    bud = 200;
    while (out_q.size() < 6 && bud > 0) begin
      step();
      bud--;
    end
    chk("flush_start", {31'd0, out_q.size() >= 6}, 32'd1);
    MAIN_OPEN_ACK = 1'b0;
    step();
    chk("flush_tx_wr", TX_WR, 0);
    chk("flush_busy", BUSY, 0);
    @(negedge CLK);
    nd = out_q.size();
    for (int i = 0; i < nd; i++) chk("flush_prefix", out_q[i], exp_q[i]);
    repeat (2) step();
    MAIN_OPEN_ACK = 1'b1;
    repeat (30) step();
    @(negedge CLK);
    chk("flush_empty", out_q.size(), nd);
    out_q.delete();
    cq.delete();
    exp_q.delete();
    close_link();
    put(4'b1000, {8'hE1, 24'd0});
    put(4'b1000, {8'hE2, 24'd0});
    put(4'b1000, {8'hE3, 24'd0});
    open_link();
    drain(1'b0);

    // random fills with random back-pressure
    for (int it = 0; it < 4; it++) begin
      close_link();
      repeat ($urandom_range(1, 40)) put(NCH'($urandom_range(0, 15)), $urandom);
      open_link();
      drain(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
